// File: rtl/conv_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer_if
//
// Purpose: Bundles the signals between the frame sequencer and its neighbours.
//          These are the frame control pulses, the read/write ready flags, the
//          frame-buffer and pipeline enables, and the output pixel coordinates
//          and status.
//
// Modports:
//   master - the system side. Drives start/abort and the ready flags, and
//            observes the enables, the coordinates and the status.
//   slave  - the sequencer itself.
//
// Signals:
//   start         one-cycle frame request
//   abort         synchronous abort back to IDLE
//   src_ready     frame buffer has an input pixel this cycle
//   dst_ready     frame buffer accepts an output pixel this cycle
//   read_enable   pop one input pixel
//   write_enable  commit one output pixel
//   conv_enable   advance the convolution pipeline one step
//   pad_sel       feed zero padding into the pipeline instead of gray_in
//   out_col       column of the pixel being written (CNT_W bits)
//   out_row       row of the pixel being written (CNT_W bits)
//   busy          frame in progress (FILL, RUN or DRAIN)
//   conv_finished frame complete; held until next start, abort or reset
// -----------------------------------------------------------------------------
interface conv_frame_sequencer_if #(
  parameter int CNT_W = 19
);
  logic             start;
  logic             abort;
  logic             src_ready;
  logic             dst_ready;
  logic             read_enable;
  logic             write_enable;
  logic             conv_enable;
  logic             pad_sel;
  logic [CNT_W-1:0] out_col;
  logic [CNT_W-1:0] out_row;
  logic             busy;
  logic             conv_finished;

  modport master (
    output start, abort, src_ready, dst_ready,
    input  read_enable, write_enable, conv_enable, pad_sel,
    input  out_col, out_row, busy, conv_finished
  );

  modport slave (
    input  start, abort, src_ready, dst_ready,
    output read_enable, write_enable, conv_enable, pad_sel,
    output out_col, out_row, busy, conv_finished
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Purpose: Sequences one 3x3 convolution pass over a WIDTH x HEIGHT frame.
//   The sequence has three phases:
//   FILL  : reads LAT pixels to prime the line buffers. Nothing is written.
//   RUN   : reads one pixel and writes one pixel per step, until the last input
//           pixel has been read.
//   DRAIN : pushes zero padding through the pipeline to flush the final LAT
//           output pixels. Nothing is read.
//   Each phase stalls cleanly on the ready flags that it depends on.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    conv_frame_sequencer_if.slave (control, handshakes, coordinates,
//          status)
//
// Parameters:
//   WIDTH, HEIGHT  frame geometry
//   LAT            accepted reads before the first valid output
//                  (0 <= LAT < WIDTH*HEIGHT)
//   CNT_W          counter width, 2**CNT_W > WIDTH*HEIGHT
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LAT    = 642,
  parameter int CNT_W  = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  conv_frame_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int               NPIX     = WIDTH * HEIGHT;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
  // Index of the read that completes the fill. It is only used when LAT > 0.
  localparam logic [CNT_W-1:0] FILL_IDX = (LAT > 0) ? CNT_W'(LAT - 1) : '0;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] col_q,    col_d;
  logic [CNT_W-1:0] row_q,    row_d;
  logic             busy_q;
  logic             done_q;

  logic             rd_en;
  logic             wr_en;
  logic             pad;

  // ---------------------------------------------------------------------------
  // Enables: combinational from the registered state and the ready flags.
  // This adds no cycle of latency between a ready flag and its enable.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    rd_en = 1'b0;
    wr_en = 1'b0;
    pad   = 1'b0;
    unique case (state_q)
      S_FILL:  rd_en = bus.src_ready;
      S_RUN: begin
        // One step consumes one input and produces one output, so it needs
        // both sides ready.
        rd_en = bus.src_ready & bus.dst_ready;
        wr_en = bus.src_ready & bus.dst_ready;
      end
      S_DRAIN: begin
        wr_en = bus.dst_ready;
        pad   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.read_enable   = rd_en;
  assign bus.write_enable  = wr_en;
  assign bus.conv_enable   = rd_en | wr_en;
  assign bus.pad_sel       = pad;
  assign bus.out_col       = col_q;
  assign bus.out_row       = row_q;
  assign bus.busy          = busy_q;
  assign bus.conv_finished = done_q;

  // ---------------------------------------------------------------------------
  // Next state and counters.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    col_d    = col_q;
    row_d    = row_q;

    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + ONE;
    end
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + ONE;
      // Raster-order coordinate of the next pixel to be written.
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = (LAT > 0) ? S_FILL : S_RUN;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          col_d    = '0;
          row_d    = '0;
        end
      end
      S_FILL: begin
        if (rd_en && rd_cnt_q == FILL_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Leave on the step that consumes the last input pixel. With LAT == 0,
        // that step also produces the last output pixel.
        if (rd_en && rd_cnt_q == LAST_IDX) begin
          state_d = (LAT > 0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        if (wr_en && wr_cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over start and over every phase transition.
    if (bus.abort) begin
      state_d  = S_IDLE;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      col_d    = '0;
      row_d    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register. busy and conv_finished are decoded from the next state, so
  // they come out registered and in step with state_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. Every register samples the same
      // pre-edge values, whatever order these lines are written in.
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      busy_q   <= (state_d == S_FILL) || (state_d == S_RUN) ||
                  (state_d == S_DRAIN);
      done_q   <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

  localparam int CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_frame_sequencer_if #(.CNT_W(CW)) ia ();
  conv_frame_sequencer_if #(.CNT_W(CW)) ib ();

  conv_frame_sequencer #(.WIDTH(4), .HEIGHT(3), .LAT(5), .CNT_W(CW)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  conv_frame_sequencer #(.WIDTH(4), .HEIGHT(3), .LAT(0), .CNT_W(CW)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  int total = 0;
  int bad   = 0;

  // Handshake monitor: counts reads and writes, logs write coordinates, and
  // flags protocol breaches.
  int rd_a = 0, wr_a = 0, viol_a = 0, rd_b = 0, wr_b = 0;
  int col_log[$];
  int row_log[$];

  always @(posedge clk) begin
    if (ia.read_enable) rd_a <= rd_a + 1;
    if (ia.write_enable) begin
      wr_a <= wr_a + 1;
      col_log.push_back(int'(ia.out_col));
      row_log.push_back(int'(ia.out_row));
    end
    if ((ia.read_enable  && !ia.src_ready) ||
        (ia.write_enable && !ia.dst_ready) ||
        (ia.read_enable  &&  ia.pad_sel)   ||
        (ia.write_enable && !ia.pad_sel && !ia.read_enable) ||
        (ia.conv_enable  != (ia.read_enable | ia.write_enable)))
      viol_a <= viol_a + 1;
    if (ib.read_enable)  rd_b <= rd_b + 1;
    if (ib.write_enable) wr_b <= wr_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {read, write, conv, pad, busy, finished}
  function automatic logic [31:0] vec_a();
    return 32'({ia.read_enable, ia.write_enable, ia.conv_enable,
                ia.pad_sel, ia.busy, ia.conv_finished});
  endfunction

  function automatic logic [31:0] vec_b();
    return 32'({ib.read_enable, ib.write_enable, ib.conv_enable,
                ib.pad_sel, ib.busy, ib.conv_finished});
  endfunction

  // Expected vector for cycle k after start: WIDTH=4, HEIGHT=3, LAT=5, both
  // sides ready. 5 FILL, 7 RUN, 5 DRAIN, then DONE.
  function automatic logic [31:0] exp_lat5(input int k);
    if (k <= 5)       return 32'b101010;
    else if (k <= 12) return 32'b111010;
    else if (k <= 17) return 32'b011110;
    else              return 32'b000001;
  endfunction

  task automatic directed_frame_a(input string tag);
    int r0, w0, c0;
    r0 = rd_a; w0 = wr_a; c0 = col_log.size();
    @(negedge clk);
    ia.start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) ia.start = 1'b0;
      check($sformatf("%s_cyc%0d", tag, k), vec_a(), exp_lat5(k));
    end
    check({tag, "_reads"},  32'(rd_a - r0), 32'd12);
    check({tag, "_writes"}, 32'(wr_a - w0), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (c0 + i < col_log.size()) begin
        check($sformatf("%s_col%0d", tag, i), 32'(col_log[c0+i]), 32'(i % 4));
        check($sformatf("%s_row%0d", tag, i), 32'(row_log[c0+i]), 32'(i / 4));
      end else begin
        check($sformatf("%s_coord%0d_missing", tag, i), 32'd0, 32'd1);
      end
    end
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int n;
    n = 0;
    while (!ia.conv_finished && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ia.conv_finished), 32'd1);
  endtask

  initial begin
    int r0, w0, v0, c0, n;
    ia.start = 1'b0; ia.abort = 1'b0; ia.src_ready = 1'b0; ia.dst_ready = 1'b0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.src_ready = 1'b0; ib.dst_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_a_vec", vec_a(), 32'd0);
    check("rst_a_pos", 32'({ia.out_col, ia.out_row}), 32'd0);
    check("rst_b_vec", vec_b(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_a_vec", vec_a(), 32'd0);

    // Full-throughput frame from IDLE, then again from DONE.
    ia.src_ready = 1'b1; ia.dst_ready = 1'b1;
    directed_frame_a("f1");
    directed_frame_a("f2");

    // Random back-pressure, plus a start while busy that must be ignored.
    r0 = rd_a; w0 = wr_a; v0 = viol_a;
    @(negedge clk);
    ia.start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ia.start     = (n == 9);
      ia.src_ready = 1'($urandom_range(0, 1));
      ia.dst_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!ia.conv_finished && n < 600);
    ia.start = 1'b0;
    check("rand_done",   32'(ia.conv_finished), 32'd1);
    check("rand_reads",  32'(rd_a - r0),        32'd12);
    check("rand_writes", 32'(wr_a - w0),        32'd12);
    check("rand_viol",   32'(viol_a - v0),      32'd0);
    ia.src_ready = 1'b1; ia.dst_ready = 1'b1;

    // LAT = 0: read and write together from the first cycle, no FILL/DRAIN.
    ib.src_ready = 1'b1; ib.dst_ready = 1'b1;
    r0 = rd_b; w0 = wr_b;
    @(negedge clk);
    ib.start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) ib.start = 1'b0;
      check($sformatf("lat0_cyc%0d", k), vec_b(), (k <= 12) ? 32'b111010 : 32'b000001);
    end
    check("lat0_reads",  32'(rd_b - r0), 32'd12);
    check("lat0_writes", 32'(wr_b - w0), 32'd12);

    // Abort during RUN with rd_cnt = 8.
    @(negedge clk);
    ia.start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) ia.start = 1'b0;
    end
    check("abort_pre_run", vec_a(), 32'b111010);
    ia.abort = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    check("abort_idle", vec_a(), 32'd0);
    c0 = col_log.size(); w0 = wr_a;
    @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    wait_done_a(100, "abort_restart_done");
    check("abort_restart_writes", 32'(wr_a - w0), 32'd12);
    if (c0 < col_log.size()) begin
      check("abort_restart_first_col", 32'(col_log[c0]), 32'd0);
      check("abort_restart_first_row", 32'(row_log[c0]), 32'd0);
    end else begin
      check("abort_restart_no_write", 32'd0, 32'd1);
    end

    // Async reset mid-DRAIN.
    @(negedge clk);
    ia.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) ia.start = 1'b0;
    end
    check("drain_pre_reset", vec_a(), 32'b011110);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vec", vec_a(), 32'd0);
    check("async_rst_pos", 32'({ia.out_col, ia.out_row}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", vec_a(), 32'd0);
    directed_frame_a("f3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences one 3x3 grayscale convolution pass over a WIDTH x HEIGHT frame.
- Drives frame-buffer read/write enables and the convolution pipeline advance.
- Accounts for the pipeline fill latency, stalls on source or sink back-pressure, and drains the pipeline with padding after the last input pixel.
- Sits between the frame-buffer read port, the convolution datapath and the frame-buffer write port. Replaces the free-running test counter.

Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- LAT, 642, accepted input pixels before the first valid output pixel (WIDTH+2 for 3x3); legal range 0 <= LAT < WIDTH*HEIGHT
- CNT_W, 19, width of pixel counters; must satisfy 2^CNT_W > WIDTH*HEIGHT

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to process a frame; ignored unless state is IDLE or DONE
- abort  input  1  synchronous abort; returns to IDLE next cycle
- src_ready  input  1  frame buffer has a pixel available to read this cycle
- dst_ready  input  1  frame buffer can accept a write this cycle
- read_enable  output  1  pop one input pixel this cycle
- write_enable  output  1  commit one output pixel this cycle
- conv_enable  output  1  advance convolution pipeline one step
- pad_sel  output  1  pipeline input is zero padding instead of gray_in
- out_col  output  CNT_W  column of pixel being written; valid when write_enable=1
- out_row  output  CNT_W  row of pixel being written; valid when write_enable=1
- busy  output  1  high in FILL, RUN or DRAIN
- conv_finished  output  1  high in DONE; held until next start, abort or reset

Behaviour:
- Reset: all outputs 0, state IDLE, rd_cnt = wr_cnt = 0, out_col = out_row = 0.
- Counters:
  - rd_cnt counts accepted reads; wr_cnt counts committed writes.
  - N = WIDTH*HEIGHT.
  - out_col/out_row are a column/row counter pair advanced on each write. out_col wraps WIDTH-1 -> 0 and increments out_row.
- IDLE/DONE, start=1: clear all counters. Go to FILL if LAT>0, else RUN. Outputs are registered from the next cycle.
- FILL:
  - read_enable = conv_enable = src_ready; write_enable = 0.
  - On the LAT-th accepted read, go to RUN.
- RUN:
  - step = src_ready & dst_ready; read_enable = write_enable = conv_enable = step.
  - When rd_cnt reaches N, go to DRAIN if LAT>0, else DONE.
  - The transition happens on the step that makes rd_cnt = N.
- DRAIN:
  - read_enable = 0; pad_sel = 1; write_enable = conv_enable = dst_ready.
  - When wr_cnt reaches N, go to DONE.
- DONE: conv_finished = 1, busy = 0, no enables asserted.
- Stalls: with the required ready low, no enable asserts, no counter moves and state holds. There is no lost or duplicated pixel.
- Invariants: exactly N reads and N writes per frame. write_enable never asserts in FILL; read_enable never asserts in DRAIN.
- Simultaneous events:
  - abort takes priority over start and over any transition.
  - start during FILL/RUN/DRAIN is ignored.
- Async reset mid-frame returns to IDLE immediately. The partially processed frame is discarded.
- Enables are combinational from registered state and the ready inputs. There is no added latency between ready and enable.

Test Plan:
- WIDTH=4, HEIGHT=3, LAT=5, src_ready=dst_ready=1, start pulse:
  - 5 cycles read-only, then 7 cycles read+write, then 5 cycles write-only with pad_sel=1.
  - conv_finished rises on cycle 18 after start; 12 reads and 12 writes total.
- Same config, check coordinates: out_col/out_row sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2) across the 12 writes.
- Random 50% toggling of src_ready/dst_ready: totals still 12/12.
  - No read when src_ready=0; no write when dst_ready=0.
  - No write in FILL; no read in DRAIN.
- LAT=0: first cycle after start reads and writes together, with no FILL/DRAIN cycles. Done after 12 stepping cycles.
- abort asserted during RUN at rd_cnt=8: state IDLE next cycle, all enables 0. A new start restarts at out_col=out_row=0.
- Async reset asserted mid-DRAIN: outputs 0 immediately. start while busy is ignored, and start from DONE runs a second full frame identically.
